// File: rtl/axi_mem_pkg.sv
// Shared constants, response codes and FSM state types for the AXI memory responder.
package axi_mem_pkg;
  localparam int ID_W   = 16;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int DATA_W = 512;
  localparam int STRB_W = 64;
  localparam int RESP_W = 2;

  localparam int BEAT_BYTES = 64;
  localparam int BEAT_LSB   = 6;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  // An offset is out of range when any bit above the line index is set.
  function automatic logic addr_err(input logic [ADDR_W-1:0] off, input int unsigned ld);
    return (off >> (BEAT_LSB + ld)) != '0;
  endfunction
endpackage

// File: rtl/axi_bus_if.sv
// AXI4 bus bundle; the master modport is the view of the endpoint that terminates the bus.
interface axi_bus_t;
  import axi_mem_pkg::*;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [SIZE_W-1:0] awsize;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [RESP_W-1:0] bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [SIZE_W-1:0] arsize;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [RESP_W-1:0] rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_bram.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module axi_mem_bram
  import axi_mem_pkg::*;
#(
  parameter int MEM_LD = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [MEM_LD-1:0] waddr_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [MEM_LD-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**MEM_LD];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    // Output holds when not enabled, which keeps a stalled read beat stable.
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave endpoint answering write and read bursts from on-chip memory,
// one outstanding burst per direction with independent write and read FSMs.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int          MEM_LD    = 10,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input logic     clk,
  input logic     rst_n,
  axi_bus_t.master axi_s
);
  wstate_t           wstate_q, wstate_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [MEM_LD-1:0] widx_q, widx_d;
  logic [LEN_W-1:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic              werr_q, werr_d, wlast_err_q, wlast_err_d;

  rstate_t           rstate_q, rstate_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [MEM_LD-1:0] ridx_q, ridx_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic              rerr_q, rerr_d;

  logic [ADDR_W-1:0] aw_off, ar_off;
  logic              ram_we, ram_re;
  logic [MEM_LD-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_size;

  assign aw_off      = axi_s.awaddr - BASE_ADDR;
  assign ar_off      = axi_s.araddr - BASE_ADDR;
  assign unused_size = ^{axi_s.awsize, axi_s.arsize};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q    <= W_IDLE;
      wid_q       <= '0;
      widx_q      <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      werr_q      <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wid_q       <= wid_d;
      widx_q      <= widx_d;
      wlen_q      <= wlen_d;
      wcnt_q      <= wcnt_d;
      werr_q      <= werr_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  // Burst length comes from awlen alone; wlast only feeds the response code.
  always_comb begin
    wstate_d      = wstate_q;
    wid_d         = wid_q;
    widx_d        = widx_q;
    wlen_d        = wlen_q;
    wcnt_d        = wcnt_q;
    werr_d        = werr_q;
    wlast_err_d   = wlast_err_q;
    ram_we        = 1'b0;
    axi_s.awready = 1'b0;
    axi_s.wready  = 1'b0;
    axi_s.bvalid  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        axi_s.awready = rst_n;
        if (axi_s.awvalid) begin
          wid_d       = axi_s.awid;
          widx_d      = aw_off[BEAT_LSB +: MEM_LD];
          wlen_d      = axi_s.awlen;
          wcnt_d      = '0;
          werr_d      = addr_err(aw_off, MEM_LD);
          wlast_err_d = 1'b0;
          wstate_d    = W_DATA;
        end
      end
      W_DATA: begin
        axi_s.wready = rst_n;
        if (axi_s.wvalid && rst_n) begin
          ram_we = !werr_q;
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (axi_s.wlast != (wcnt_q == wlen_q)) wlast_err_d = 1'b1;
          if (wcnt_q == wlen_q) wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        axi_s.bvalid = rst_n;
        if (axi_s.bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign axi_s.bid   = wid_q;
  assign axi_s.bresp = (werr_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rerr_q   <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      ridx_q   <= ridx_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rerr_q   <= rerr_d;
    end
  end

  // Prefetch index+1 on each accepted beat so a held rready streams one beat per cycle.
  always_comb begin
    rstate_d      = rstate_q;
    rid_d         = rid_q;
    ridx_d        = ridx_q;
    rlen_d        = rlen_q;
    rcnt_d        = rcnt_q;
    rerr_d        = rerr_q;
    ram_re        = 1'b0;
    ram_raddr     = ridx_q;
    axi_s.arready = 1'b0;
    axi_s.rvalid  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        axi_s.arready = rst_n;
        if (axi_s.arvalid) begin
          rid_d    = axi_s.arid;
          ridx_d   = ar_off[BEAT_LSB +: MEM_LD];
          rlen_d   = axi_s.arlen;
          rcnt_d   = '0;
          rerr_d   = addr_err(ar_off, MEM_LD);
          rstate_d = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re   = 1'b1;
        rstate_d = R_DATA;
      end
      R_DATA: begin
        axi_s.rvalid = rst_n;
        if (axi_s.rready && rst_n) begin
          ram_re    = 1'b1;
          ram_raddr = ridx_q + 1'b1;
          ridx_d    = ridx_q + 1'b1;
          rcnt_d    = rcnt_q + 1'b1;
          if (rcnt_q == rlen_q) rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign axi_s.rid   = rid_q;
  assign axi_s.rresp = rerr_q ? RESP_SLVERR : RESP_OKAY;
  assign axi_s.rlast = (rstate_q == R_DATA) && (rcnt_q == rlen_q);
  assign axi_s.rdata = (rstate_q == R_DATA && !rerr_q) ? ram_rdata : '0;

  axi_mem_bram #(.MEM_LD(MEM_LD)) u_bram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (widx_q),
    .wstrb_i (axi_s.wstrb),
    .wdata_i (axi_s.wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed vector table, reset and
// concurrency sequences, then random bursts against a line-array memory model.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  localparam int          MEM_LD = 10;
  localparam int          DEPTH  = 1 << MEM_LD;
  localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_bus_t bus ();

  axi_mem_responder #(.MEM_LD(MEM_LD), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi_s (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] ref_mem   [DEPTH];
  logic [DATA_W-1:0] wbuf_data [256];
  logic [STRB_W-1:0] wbuf_strb [256];
  logic [DATA_W-1:0] rbuf      [256];

  typedef struct {
    bit          is_wr;
    logic [15:0] id;
    logic [63:0] off;
    int          len;
    int          dmode;   // 0: beat index, 1: 0x55 fill, 2: 0xAA fill, 3: random
    logic [63:0] strb;
    int          bad_beat;
    int          rmode;   // 0: rready held, 1: 1,0,0 pattern, 2: random
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int line_of(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE;
    return int'((off / 64) % DEPTH);
  endfunction

  function automatic bit is_err(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE;
    return off >= 64'(DEPTH * BEAT_BYTES);
  endfunction

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] d;
    for (int j = 0; j < DATA_W / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic axi_write(input logic [15:0] id, input logic [63:0] addr, input int len,
                           input int bad_beat, input logic [1:0] exp_resp);
    int t;
    int ln;
    bit err;
    logic [15:0] got_id;
    logic [1:0]  got_resp;
    ln  = line_of(addr);
    err = is_err(addr);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = 3'd6; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin chk("aw_timeout", bus.awready, 1); bus.awvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    chk("aw_to_wready", bus.wready, 1);
    for (int k = 0; k <= len; k++) begin
      bus.wdata = wbuf_data[k]; bus.wstrb = wbuf_strb[k];
      bus.wlast = (k == len) ^ (k == bad_beat); bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) begin chk("w_timeout", bus.wready, 1); bus.wvalid = 1'b0; return; end
      @(posedge clk); #1;
      if (!err)
        for (int b = 0; b < STRB_W; b++)
          if (wbuf_strb[k][b]) ref_mem[(ln + k) % DEPTH][b*8 +: 8] = wbuf_data[k][b*8 +: 8];
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("w_to_bvalid", bus.bvalid, 1);
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin chk("b_timeout", bus.bvalid, 1); bus.bready = 1'b0; return; end
    got_id = bus.bid; got_resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    chk("bid", got_id, id);
    chk("bresp", got_resp, exp_resp);
    $display("WR id=%h addr=%h len=%0d bresp=%0d", id, addr, len, got_resp);
  endtask

  task automatic axi_read(input logic [15:0] id, input logic [63:0] addr, input int len,
                          input int mode, input logic [1:0] exp_resp);
    int t, k, cyc, ln;
    bit err, stalled;
    logic [DATA_W-1:0] h_data, exp_data;
    logic h_last;
    logic [15:0] h_id;
    logic [1:0]  h_resp;
    ln  = line_of(addr);
    err = is_err(addr);
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = 3'd6; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin chk("ar_timeout", bus.arready, 1); bus.arvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    chk("ar_to_rvalid_c1", bus.rvalid, 0);
    @(posedge clk); #1;
    chk("ar_to_rvalid_c2", bus.rvalid, 1);
    k = 0; cyc = 0; stalled = 0;
    h_data = '0; h_last = 1'b0; h_id = '0; h_resp = '0;
    while (k <= len && cyc < 2000) begin
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (cyc % 3 == 0);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      if (!bus.rvalid) begin
        chk("rvalid_in_burst", bus.rvalid, 1);
        break;
      end
      if (stalled) begin
        chk("r_hold_data", bus.rdata, h_data);
        chk("r_hold_last", bus.rlast, h_last);
        chk("r_hold_id", bus.rid, h_id);
        chk("r_hold_resp", bus.rresp, h_resp);
      end
      if (bus.rready) begin
        exp_data = err ? '0 : ref_mem[(ln + k) % DEPTH];
        chk("rdata", bus.rdata, exp_data);
        chk("rlast", bus.rlast, k == len);
        chk("rid", bus.rid, id);
        chk("rresp", bus.rresp, exp_resp);
        rbuf[k] = bus.rdata;
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        h_data = bus.rdata; h_last = bus.rlast; h_id = bus.rid; h_resp = bus.rresp;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    if (k <= len) chk("r_beats", k, len + 1);
    if (mode == 0) chk("r_throughput_cycles", cyc, len + 1);
    $display("RD id=%h addr=%h len=%0d beats=%0d cycles=%0d", id, addr, len, k, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    vecs[0]  = '{1'b1, 16'h0012, 64'h40,         3, 0, ALL1,     -1, 0, RESP_OKAY};
    vecs[1]  = '{1'b0, 16'h0034, 64'h40,         3, 0, ALL1,     -1, 0, RESP_OKAY};
    vecs[2]  = '{1'b1, 16'h0005, 64'h140,        0, 1, ALL1,     -1, 0, RESP_OKAY};
    vecs[3]  = '{1'b1, 16'h0006, 64'h140,        0, 2, 64'hFF,   -1, 0, RESP_OKAY};
    vecs[4]  = '{1'b0, 16'h0007, 64'h140,        0, 0, ALL1,     -1, 0, RESP_OKAY};
    vecs[5]  = '{1'b0, 16'h0008, 64'h0,          7, 0, ALL1,     -1, 1, RESP_OKAY};
    vecs[6]  = '{1'b0, 16'h0009, 64'h200,        7, 0, ALL1,     -1, 0, RESP_OKAY};
    vecs[7]  = '{1'b1, 16'h000A, 64'h10000,      0, 3, ALL1,     -1, 0, RESP_SLVERR};
    vecs[8]  = '{1'b0, 16'h000B, 64'h0,          0, 0, ALL1,     -1, 0, RESP_OKAY};
    vecs[9]  = '{1'b0, 16'h000C, 64'h10000,      0, 0, ALL1,     -1, 0, RESP_SLVERR};
    vecs[10] = '{1'b1, 16'h000D, 64'h280,        1, 3, ALL1,      0, 0, RESP_SLVERR};
    vecs[11] = '{1'b1, 16'h000E, 64'hFF80,       3, 3, ALL1,     -1, 0, RESP_OKAY};
    vecs[12] = '{1'b0, 16'h000F, 64'hFF80,       3, 0, ALL1,     -1, 2, RESP_OKAY};
    vecs[13] = '{1'b0, 16'h0010, -64'sd64,       0, 0, ALL1,     -1, 0, RESP_SLVERR};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bid", bus.bid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rid", bus.rid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_rlast", bus.rlast, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_awready", bus.awready, 1);
    chk("post_rst_arready", bus.arready, 1);

    // Preload lines 0..63 so every later read has a known reference
    for (int k = 0; k < 64; k++) begin wbuf_data[k] = rand_line(); wbuf_strb[k] = ALL1; end
    axi_write(16'h0001, BASE, 63, -1, RESP_OKAY);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      a = BASE + vecs[i].off;
      if (vecs[i].is_wr) begin
        for (int k = 0; k <= vecs[i].len; k++) begin
          case (vecs[i].dmode)
            0:       wbuf_data[k] = DATA_W'(k);
            1:       wbuf_data[k] = {STRB_W{8'h55}};
            2:       wbuf_data[k] = {STRB_W{8'hAA}};
            default: wbuf_data[k] = rand_line();
          endcase
          wbuf_strb[k] = vecs[i].strb;
        end
        axi_write(vecs[i].id, a, vecs[i].len, vecs[i].bad_beat, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].id, a, vecs[i].len, vecs[i].rmode, vecs[i].exp_resp);
      end
      if (i == 1)
        for (int k = 0; k < 4; k++) chk("t1_beat_value", rbuf[k], DATA_W'(k));
      if (i == 4)
        chk("strb_merge", rbuf[0], {{56{8'h55}}, {8{8'hAA}}});
    end

    // Reset during write beat 2 of 4
    bus.awid = 16'h0077; bus.awaddr = BASE + 64'(20 * 64); bus.awlen = 8'd3; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.wdata = rand_line(); bus.wstrb = ALL1; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      ref_mem[20 + k] = bus.wdata;
    end
    bus.wdata = rand_line(); rst_n = 1'b0;
    #1;
    chk("midrst_awready_low", bus.awready, 0);
    chk("midrst_wready_low", bus.wready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wrst_awready", bus.awready, 1);
    chk("wrst_arready", bus.arready, 1);
    chk("wrst_bvalid", bus.bvalid, 0);

    // Reset during read beat 1 of 4
    bus.arid = 16'h0078; bus.araddr = BASE + 64'(20 * 64); bus.arlen = 8'd3; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(posedge clk); #1;
    bus.rready = 1'b1;
    chk("rrst_beat0", bus.rdata, ref_mem[20]);
    @(posedge clk); #1;
    bus.rready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rrst_awready", bus.awready, 1);
    chk("rrst_arready", bus.arready, 1);
    for (int c = 0; c < 3; c++) begin
      chk("rst_no_bvalid", bus.bvalid, 0);
      chk("rst_no_rvalid", bus.rvalid, 0);
      @(posedge clk); #1;
    end
    axi_read(16'h0079, BASE + 64'(20 * 64), 3, 0, RESP_OKAY);

    // AW and AR accepted together on disjoint lines
    for (int k = 0; k < 2; k++) begin wbuf_data[k] = rand_line(); wbuf_strb[k] = ALL1; end
    fork
      axi_write(16'h0090, BASE + 64'(30 * 64), 1, -1, RESP_OKAY);
      axi_read(16'h0091, BASE + 64'(40 * 64), 3, 0, RESP_OKAY);
    join
    axi_read(16'h0092, BASE + 64'(30 * 64), 1, 0, RESP_OKAY);

    // Random bursts against the model, lines 0..63 only
    for (int n = 0; n < 20; n++) begin
      int wl, wln, rl, rln;
      wl  = $urandom_range(0, 3);
      wln = $urandom_range(0, 60);
      for (int k = 0; k <= wl; k++) begin
        wbuf_data[k] = rand_line();
        wbuf_strb[k] = {$urandom, $urandom};
      end
      axi_write(16'($urandom), BASE + 64'(wln * 64) + 64'($urandom_range(0, 63)), wl, -1, RESP_OKAY);
      rl  = $urandom_range(0, 3);
      rln = $urandom_range(0, 60);
      axi_read(16'($urandom), BASE + 64'(rln * 64), rl, 2, RESP_OKAY);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI4 slave endpoint that terminates an axi_bus_t and answers write and read bursts from on-chip byte-enabled memory. Used as the far end behind register slices and interconnect for bring-up, loopback and memory-model testing. Writes and reads run in independent FSMs. Each direction has one outstanding burst, responses in order.

Parameters:
MEM_LD, 10, log2 of memory depth in 512-bit lines (default 1024 lines = 64 KiB)
BASE_ADDR, 64'h0, byte address mapped to line 0

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
axi_s  axi_bus_t.master modport  -  slave-side AXI port. Fields: id 16, addr 64, len 8, size 3, data 512, strb 64, resp 2, plus last/valid/ready per channel.

Behaviour:
Interface decision: one clock `clk`; reset `rst_n` is synchronous and active-low.

Reset:
- awready, wready, bvalid, arready and rvalid are 0 while rst_n=0.
- bid, bresp, rid, rdata, rresp and rlast reset to 0.
- Memory contents are not cleared.

Address and decode:
- Every beat is 64 B. awsize/arsize are ignored; all bursts are treated as INCR.
- Line index = (addr - BASE_ADDR)[6 +: MEM_LD]. Low 6 address bits are ignored.
- The index wraps modulo depth within a burst.
- Decode error: any bit of (addr - BASE_ADDR) at or above bit 6+MEM_LD is set. Evaluated once, on the start address.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On AW handshake, latch awid, index, err and beats=awlen+1; go to W_DATA.
- W_DATA: wready=1. Each W handshake writes wdata to memory under the wstrb byte enables; write is suppressed if err. Index increments.
- Leave W_DATA on the final beat (count reaches beats) → W_RESP. wlast is not used to terminate.
- If wlast disagrees with the count, the transfer still completes and bresp=SLVERR.
- W_RESP: bvalid=1, bid=latched id, bresp = SLVERR if err or wlast mismatch, else OKAY. Hold until bready, then go to W_IDLE.
- wready is 0 outside W_DATA; W data presented before AW is stalled.
- Latency: AW handshake to first wready = 1 cycle. Last W to bvalid = 1 cycle.

Read FSM (R_IDLE, R_FETCH, R_DATA):
- R_IDLE: arready=1. On AR handshake, latch arid, index, err and beats; go to R_FETCH.
- R_FETCH: memory read of the index is registered (1-cycle RAM); go to R_DATA.
- R_DATA: rvalid=1, rdata = RAM output (all zeros if err), rresp = SLVERR if err else OKAY, rid = latched id, rlast=1 on the final beat.
- Each R handshake advances the index. The RAM read address is index+1 when a handshake occurs that cycle, so rready held high gives 1 beat per cycle.
- While rready=0, rdata, rlast, rid and rresp are held stable.
- After the final-beat handshake, go to R_IDLE.
- Latency: AR handshake to first rvalid = 2 cycles.

Simultaneous events:
- Read and write may target the same line in the same cycle; the read returns old data (read-first).
- AW and AR may be accepted in the same cycle.

Reset mid-burst:
- Both FSMs return to idle and the in-flight burst is abandoned; no B/R is issued for it.
- Partially written lines keep the beats already written.

Decomposition:
- Package axi_mem_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - BEAT_BYTES=64 and BEAT_LSB=6
  - field width constants for id/addr/len/data/strb
  - the wstate_t and rstate_t enums
- Sub-module axi_mem_bram: simple dual-port RAM, 512-bit data, 64 byte enables, registered read-first output, depth 2^MEM_LD.

Test Plan:
1. AW id=0x12, addr=0x40, len=3; W beats with data=k and strb all ones; then AR same addr, len=3 → bresp=OKAY, bid=0x12; R beats return 0..3, rlast only on beat 3, rid matches arid.
2. Write line 5 with strb=64'h00000000000000FF and data all 0xAA over a line preloaded with 0x55 → readback has low 8 bytes 0xAA and the rest 0x55.
3. AR len=7 with rready toggling 1,0,0,1… → each beat is held stable while stalled; 8 beats delivered in order; with rready held 1, beats 2-8 arrive 1 per cycle.
4. AW addr = BASE_ADDR + 2^(6+MEM_LD), len=0 → bresp=SLVERR and memory unchanged; AR to the same addr → rresp=SLVERR, rdata=0.
5. AW len=1 with wlast asserted on beat 0 → 2 beats accepted, bresp=SLVERR.
6. rst_n pulsed low mid-burst (write beat 2 of 4; read beat 1 of 4) → no bvalid or rvalid afterwards; awready and arready are 1 the cycle after rst_n returns high; the next burst completes normally.
